// File: rtl/com_tx_if.sv
// Request, RAM-read and link-byte signals of the collect-link packet transmitter.
// The master side is the frame requester, which also hosts the transmit RAM.
interface com_tx_if;
  logic        fs;
  logic        fd;
  logic [3:0]  btype;
  logic [7:0]  bdata;
  logic [3:0]  device_idx;
  logic [3:0]  data_idx;
  logic [3:0]  device_stat;
  logic [11:0] data_len;
  logic [11:0] ram_rxa_init;
  logic [11:0] ram_rxa;
  logic [7:0]  ram_rxd;
  logic [7:0]  com_txd;
  logic        com_txen;

  modport master (
    output fs, btype, bdata, device_idx, data_idx, device_stat, data_len,
           ram_rxa_init, ram_rxd,
    input  fd, ram_rxa, com_txd, com_txen
  );

  modport slave (
    input  fs, btype, bdata, device_idx, data_idx, device_stat, data_len,
           ram_rxa_init, ram_rxd,
    output fd, ram_rxa, com_txd, com_txen
  );
endinterface

// File: rtl/com_tx.sv
// Byte-serial collect-link transmitter: frames handshake, status and data packets.
// CRC5 (poly 0x05, init 1F) and CRC16 (poly 0x8005, init FFFF) run LSB-first, reflected, uninverted.
module com_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input logic   clk,
  input logic   rst,
  com_tx_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_PID, S_LEN0, S_LEN1, S_SDAT0, S_SDAT1, S_CRC5,
    S_HEAD0, S_HEAD1, S_DATA, S_CRC160, S_CRC161, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  btype_q, dev_q, didx_q, dstat_q;
  logic [7:0]  bdata_q;
  logic [11:0] len_q, init_q, cnt_q, frame_len;
  logic [4:0]  crc5_q;
  logic [15:0] crc16_q;
  logic [7:0]  byte_d;
  logic        txen_d, crc5_en, crc16_en, last_data;

  function automatic logic [4:0] crc5_upd(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 5'h14) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic logic is_hs(input logic [3:0] t);
    return t inside {4'b0001, 4'b0010, 4'b0011};
  endfunction

  function automatic logic is_status(input logic [3:0] t);
    return t inside {4'b1000, 4'b1001, 4'b1010};
  endfunction

  function automatic logic is_data(input logic [3:0] t);
    return t inside {4'b1101, 4'b1110};
  endfunction

  function automatic logic [7:0] pid_of(input logic [3:0] t);
    case (t)
      4'b0001: return 8'h2D;
      4'b0010: return 8'hA5;
      4'b0011: return 8'hE1;
      4'b1101: return 8'h96;
      4'b1110: return 8'h5A;
      default: return 8'hD2;
    endcase
  endfunction

  function automatic logic [3:0] head_of(input logic [3:0] t);
    case (t)
      4'b1000: return 4'hD;
      4'b1001: return 4'h1;
      default: return 4'h9;
    endcase
  endfunction

  assign frame_len = len_q + 12'd2;
  assign last_data = (cnt_q == len_q - 12'd1);
  assign bus.fd    = (state_q == S_DONE);

  // Each state names the byte loaded into com_txd on the edge that leaves it.
  always_comb begin
    state_d  = state_q;
    byte_d   = IDLE_BYTE;
    txen_d   = 1'b0;
    crc5_en  = 1'b0;
    crc16_en = 1'b0;
    case (state_q)
      S_IDLE:
        if (bus.fs)
          state_d = (is_hs(bus.btype) || is_status(bus.btype) || is_data(bus.btype))
                    ? S_SYNC : S_DONE;
      S_SYNC:  begin byte_d = 8'h0F; txen_d = 1'b1; state_d = S_PID; end
      S_PID: begin
        byte_d  = pid_of(btype_q);
        txen_d  = 1'b1;
        state_d = is_hs(btype_q) ? S_DONE : S_LEN0;
      end
      S_LEN0: begin
        byte_d  = is_status(btype_q) ? 8'h00 : {4'h0, frame_len[11:8]};
        txen_d  = 1'b1;
        state_d = S_LEN1;
      end
      S_LEN1: begin
        byte_d  = is_status(btype_q) ? 8'h02 : frame_len[7:0];
        txen_d  = 1'b1;
        state_d = is_status(btype_q) ? S_SDAT0 : S_HEAD0;
      end
      S_SDAT0: begin
        byte_d = {head_of(btype_q), dev_q}; txen_d = 1'b1; crc5_en = 1'b1; state_d = S_SDAT1;
      end
      S_SDAT1: begin
        byte_d = bdata_q; txen_d = 1'b1; crc5_en = 1'b1; state_d = S_CRC5;
      end
      S_CRC5:  begin byte_d = {3'b000, crc5_q}; txen_d = 1'b1; state_d = S_DONE; end
      S_HEAD0: begin
        byte_d = {4'h3, dev_q}; txen_d = 1'b1; crc16_en = 1'b1; state_d = S_HEAD1;
      end
      S_HEAD1: begin
        byte_d   = {didx_q, dstat_q};
        txen_d   = 1'b1;
        crc16_en = 1'b1;
        state_d  = (len_q == 12'd0) ? S_CRC160 : S_DATA;
      end
      S_DATA: begin
        byte_d   = bus.ram_rxd;
        txen_d   = 1'b1;
        crc16_en = 1'b1;
        state_d  = last_data ? S_CRC160 : S_DATA;
      end
      S_CRC160: begin byte_d = crc16_q[15:8]; txen_d = 1'b1; state_d = S_CRC161; end
      S_CRC161: begin byte_d = crc16_q[7:0];  txen_d = 1'b1; state_d = S_DONE;   end
      S_DONE:   if (!bus.fs) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The address runs one word ahead so each RAM word lands the cycle it is sent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bus.com_txd  <= IDLE_BYTE;
      bus.com_txen <= 1'b0;
      bus.ram_rxa  <= 12'd0;
    end else begin
      state_q      <= state_d;
      bus.com_txd  <= byte_d;
      bus.com_txen <= txen_d;
      if (state_q == S_LEN0 && is_data(btype_q))
        bus.ram_rxa <= init_q;
      else if (state_d == S_DATA)
        bus.ram_rxa <= bus.ram_rxa + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.fs) begin
      btype_q <= bus.btype;
      bdata_q <= bus.bdata;
      dev_q   <= bus.device_idx;
      didx_q  <= bus.data_idx;
      dstat_q <= bus.device_stat;
      len_q   <= bus.data_len;
      init_q  <= bus.ram_rxa_init;
    end
    if (state_q == S_HEAD1)
      cnt_q <= 12'd0;
    else if (state_q == S_DATA)
      cnt_q <= cnt_q + 12'd1;
    if (state_q == S_IDLE) begin
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
    end else begin
      if (crc5_en)  crc5_q  <= crc5_upd(crc5_q, byte_d);
      if (crc16_en) crc16_q <= crc16_upd(crc16_q, byte_d);
    end
  end

endmodule

// File: doc/com_tx.md
Name: com_tx

Overview:
- Byte-serial packet transmitter for the collect link; counterpart of the link receiver on the far end.
- Frames handshake, status and data packets: SYNC, PID, optional length, header and payload bytes, then CRC.
- Payload bytes are read from a transmit RAM. Started by a level request on fs; reports completion on fd.
- Reuses the codebase crc5/crc16 engines (clk, enable, din, dout; registered dout, updated one cycle after an enabled byte).

Parameters:
IDLE_BYTE, 8'h00, value driven on com_txd whenever com_txen is low.

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
fs  in  1  send request, level; sampled in IDLE
fd  out  1  frame finished; high in DONE
btype  in  4  packet type: ACK 4'b0001, NAK 4'b0010, STALL 4'b0011, DLINK 4'b1000, DTYPE 4'b1001, DTEMP 4'b1010, DATA0 4'b1101, DATA1 4'b1110
bdata  in  8  status data byte
device_idx  in  4  device index
data_idx  in  4  data index (data packets)
device_stat  in  4  device status (data packets)
data_len  in  12  payload byte count N, 0..4093
ram_rxa_init  in  12  RAM address of payload byte 0
ram_rxa  out  12  RAM read address; synchronous RAM, one-cycle read latency
ram_rxd  in  8  RAM read data
com_txd  out  8  link byte, registered
com_txen  out  1  com_txd carries a frame byte, registered

Behaviour:
- Reset values: state IDLE; com_txd = IDLE_BYTE; com_txen = 0; fd = 0; ram_rxa = 0. Reset mid-frame aborts immediately. The next frame after reset starts from SYNC.
- IDLE: on the edge where fs = 1, latch btype, bdata, device_idx, data_idx, device_stat, data_len and ram_rxa_init. Later input changes are ignored until DONE.
- The first frame byte (SYNC 8'h0F) appears on com_txd with com_txen = 1 on the edge after fs is sampled. Frame bytes are back-to-back with no gaps, one byte per clk.
- PIDs: ACK 8'h2D, NAK 8'hA5, STALL 8'hE1, status 8'hD2, DATA0 8'h96, DATA1 8'h5A.
- Handshake (ACK/NAK/STALL) states: SYNC, PID, then DONE. 2 bytes.
- Status (DLINK/DTYPE/DTEMP) states: SYNC, PID, LEN0, LEN1, SDAT0, SDAT1, CRC5, DONE.
  - LEN0 sends 8'h00 and LEN1 sends 8'h02 (length fixed at 2).
  - SDAT0 sends {head, device_idx}; head is 4'hD for DLINK, 4'h1 for DTYPE, 4'h9 for DTEMP.
  - SDAT1 sends bdata.
  - CRC5 sends crc5 dout[7:0].
  - 7 bytes total.
- Data (DATA0/DATA1) states: SYNC, PID, LEN0, LEN1, HEAD0, HEAD1, DATA, CRC160, CRC161, DONE.
  - L = N+2 (12 bits). LEN0 sends {4'h0, L[11:8]}; LEN1 sends L[7:0].
  - HEAD0 sends {4'h3, device_idx}; HEAD1 sends {data_idx, device_stat}.
  - DATA lasts exactly N cycles; payload byte i is the RAM word at ram_rxa_init+i. If N = 0, go from HEAD1 straight to CRC160.
  - CRC160 sends crc16 dout[15:8]; CRC161 sends dout[7:0].
  - N+8 bytes total.
- RAM addressing: drive ram_rxa = ram_rxa_init during LEN1. Increment once per DATA cycle so each ram_rxd arrives the cycle it is loaded into com_txd. The address wraps mod 4096. ram_rxa holds its value outside DATA.
- CRC:
  - Both engines are enabled, with din equal to the byte being loaded into com_txd, for SDAT0/SDAT1 (crc5) and for HEAD0/HEAD1/DATA (crc16).
  - Both engines are reinitialised between frames. SYNC, PID and length bytes are excluded from the CRC.
  - The registered dout is final when the CRC state loads it.
- Unsupported btype (any other code, including 4'b0000): no bytes are sent and com_txen stays 0. The FSM goes IDLE to DONE.
- DONE: com_txen = 0, com_txd = IDLE_BYTE, fd = 1. Return to IDLE on the first edge with fs = 0; a new frame needs fs low then high again.
- Width rules: the length field is 12 bits; data_len > 4093 is out of contract (L truncated mod 4096, behaviour undefined).

Test Plan:
- Reset, then fs=1 with btype ACK -> com_txd 0F, 2D on two consecutive edges with com_txen=1, then fd=1. Drop fs -> fd=0 on the next edge.
- btype DTEMP, device_idx 5, bdata 8'h3C -> bytes 0F, D2, 00, 02, 95, 3C, crc5; the crc5 byte matches the reference model over {95, 3C}. 7 com_txen cycles.
- btype DATA0, N=3, ram_rxa_init 12'hFFE, RAM[FFE]=11, [FFF]=22, [000]=33 -> bytes 0F, 96, 00, 05, 3x, {data_idx,device_stat}, 11, 22, 33, CRC hi, CRC lo. ram_rxa wraps to 000; CRC16 matches the model.
- btype DATA1, N=0 -> 8 bytes: 0F, 5A, 00, 02, HEAD0, HEAD1, CRC hi, CRC lo. No RAM bytes are sent.
- btype 4'b0000 with fs=1 -> com_txen never asserts and fd=1 the cycle after the request. Back-to-back frames with fs held high -> exactly one frame.
- Assert rst low mid-DATA of an N=100 frame -> com_txen=0, com_txd=IDLE_BYTE, fd=0 immediately. The next request produces a complete, correct frame with a fresh CRC.
